// File: rtl/system_bus_pkg.sv
// Shared definitions for the system bus interconnect.
// Holds the FSM state encodings, response status constants and the
// reset / enable polarity constants reused across the bus files.
package system_bus_pkg;

  // Bus controller states
  typedef enum logic [1:0] {
    BUS_STATE_IDLE    = 2'd0,
    BUS_STATE_ACCESS  = 2'd1,
    BUS_STATE_ERROR   = 2'd2,
    BUS_STATE_RESPOND = 2'd3
  } bus_state_t;

  // Response status carried on master_error
  localparam logic BUS_ERROR = 1'b1;
  localparam logic BUS_OK    = 1'b0;

  // Polarity of the reset input and of a slave chip-enable (request) bit
  localparam logic RESET_ENABLE = 1'b1;
  localparam logic CHIP_ENABLE  = 1'b1;

endpackage

// File: rtl/system_bus_timeout_counter.sv
// bus_timeout_counter: counts waiting cycles of a slave access.
// Latency: o_expired is combinational from the count; count updates each edge.
// Backpressure: none; saturates at TIMEOUT_CYCLES-1 until cleared.
// Ports:
//   i_clock, i_reset  - clock and synchronous active-high reset
//   i_clear           - forces the count to zero (has priority over i_enable)
//   i_enable          - advance the count by one this cycle
//   o_expired         - count has reached TIMEOUT_CYCLES-1
module bus_timeout_counter
  import system_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [COUNT_WIDTH-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (i_reset == RESET_ENABLE || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != COUNT_LAST)) begin
      // Hold at the last value so the count can never wrap back to zero
      r_count <= r_count + COUNT_WIDTH'(1);
    end
  end

  assign o_expired = (r_count == COUNT_LAST);

endmodule

// File: rtl/system_bus.sv
// system_bus: single-master interconnect from the cpu data port to SLAVE_COUNT slaves.
// Latency: zero-wait slave completes 2 cycles after the request; unmapped errors at cycle 2.
// Backpressure: master is held by master_ready; slaves stall via slave_ready up to TIMEOUT_CYCLES.
// Ports:
//   clock, reset                    - clock and synchronous active-high reset
//   master_request/write/address/select/write_data - master request, held until master_ready
//   master_ready/error/read_data    - one-cycle registered response
//   slave_request                   - one-hot request to the decoded slave during ACCESS
//   slave_write/address/select/write_data - latched copy of the accepted request
//   slave_ready, slave_read_data    - per-slave completion and packed read data
module system_bus
  import system_bus_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int SLAVE_COUNT    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              master_request,
  input  logic                              master_write,
  input  logic [ADDRESS_WIDTH-1:0]          master_address,
  input  logic [DATA_WIDTH/8-1:0]           master_select,
  input  logic [DATA_WIDTH-1:0]             master_write_data,
  output logic                              master_ready,
  output logic                              master_error,
  output logic [DATA_WIDTH-1:0]             master_read_data,
  output logic [SLAVE_COUNT-1:0]            slave_request,
  output logic                              slave_write,
  output logic [ADDRESS_WIDTH-1:0]          slave_address,
  output logic [DATA_WIDTH/8-1:0]           slave_select,
  output logic [DATA_WIDTH-1:0]             slave_write_data,
  input  logic [SLAVE_COUNT-1:0]            slave_ready,
  input  logic [SLAVE_COUNT*DATA_WIDTH-1:0] slave_read_data
);

  localparam int SLAVE_BITS   = $clog2(SLAVE_COUNT);
  localparam int SELECT_WIDTH = DATA_WIDTH / 8;
  // One extra bit so SLAVE_COUNT itself is representable for the mapped check
  localparam logic [SLAVE_BITS:0] SLAVE_LIMIT = (SLAVE_BITS + 1)'(SLAVE_COUNT);

  bus_state_t r_state;
  bus_state_t w_state_next;

  logic                     r_write;
  logic [ADDRESS_WIDTH-1:0] r_address;
  logic [SELECT_WIDTH-1:0]  r_select;
  logic [DATA_WIDTH-1:0]    r_write_data;
  logic [SLAVE_BITS-1:0]    r_index;
  logic                     r_error;
  logic [DATA_WIDTH-1:0]    r_read_data;

  logic [SLAVE_BITS-1:0]    w_index;
  logic                     w_mapped;
  logic                     w_ready_sel;
  logic [DATA_WIDTH-1:0]    w_data_sel;
  logic [SLAVE_COUNT-1:0]   w_slave_request;
  logic                     w_expired;
  logic                     w_accept;
  logic                     w_capture;
  logic                     w_error_next;
  logic [DATA_WIDTH-1:0]    w_read_next;
  logic                     w_in_access;

  // Region decode from the top address bits
  assign w_index  = master_address[ADDRESS_WIDTH-1 -: SLAVE_BITS];
  assign w_mapped = ({1'b0, w_index} < SLAVE_LIMIT);

  assign w_in_access = (r_state == BUS_STATE_ACCESS);

  // Select the latched slave's ready/data. The loop form keeps the mux
  // in range even when the latched index is one of the unmapped codes.
  always_comb begin
    w_ready_sel     = 1'b0;
    w_data_sel      = '0;
    w_slave_request = '0;
    for (int i = 0; i < SLAVE_COUNT; i++) begin
      if (r_index == SLAVE_BITS'(i)) begin
        w_ready_sel        = slave_ready[i];
        w_data_sel         = slave_read_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_slave_request[i] = w_in_access ? CHIP_ENABLE : ~CHIP_ENABLE;
      end
    end
  end

  // Counter is held at zero outside ACCESS, so entry to ACCESS always
  // starts from a clean count.
  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_clear  (!w_in_access),
    .i_enable (w_in_access && !w_ready_sel),
    .o_expired(w_expired)
  );

  always_ff @(posedge clock) begin
    if (reset == RESET_ENABLE) begin
      r_state <= BUS_STATE_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_error_next = BUS_OK;
    w_read_next  = '0;
    case (r_state)
      BUS_STATE_IDLE: begin
        if (master_request) begin
          w_accept     = 1'b1;
          w_state_next = w_mapped ? BUS_STATE_ACCESS : BUS_STATE_ERROR;
        end
      end
      BUS_STATE_ACCESS: begin
        // Ready is tested first so a completion on the last allowed cycle is not an error
        if (w_ready_sel) begin
          w_capture    = 1'b1;
          w_read_next  = r_write ? '0 : w_data_sel;
          w_state_next = BUS_STATE_RESPOND;
        end else if (w_expired) begin
          w_capture    = 1'b1;
          w_error_next = BUS_ERROR;
          w_state_next = BUS_STATE_RESPOND;
        end
      end
      BUS_STATE_ERROR: begin
        w_capture    = 1'b1;
        w_error_next = BUS_ERROR;
        w_state_next = BUS_STATE_RESPOND;
      end
      BUS_STATE_RESPOND: begin
        w_state_next = BUS_STATE_IDLE;
      end
      default: begin
        w_state_next = BUS_STATE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset == RESET_ENABLE) begin
      r_write      <= 1'b0;
      r_address    <= '0;
      r_select     <= '0;
      r_write_data <= '0;
      r_index      <= '0;
      r_error      <= 1'b0;
      r_read_data  <= '0;
    end else begin
      if (w_accept) begin
        r_write      <= master_write;
        r_address    <= master_address;
        r_select     <= master_select;
        r_write_data <= master_write_data;
        r_index      <= w_index;
      end
      if (w_capture) begin
        r_error     <= w_error_next;
        r_read_data <= w_read_next;
      end
    end
  end

  assign master_ready     = (r_state == BUS_STATE_RESPOND);
  assign master_error     = master_ready & r_error;
  assign master_read_data = master_ready ? r_read_data : '0;

  assign slave_request    = w_slave_request;
  assign slave_write      = r_write;
  assign slave_address    = r_address;
  assign slave_select     = r_select;
  assign slave_write_data = r_write_data;

endmodule

// File: tb/tb_system_bus.sv
// Directed bench for system_bus with SLAVE_COUNT=3 and TIMEOUT_CYCLES=8.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
module tb_system_bus;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SC = 3;
  localparam int TO = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          master_request;
  logic          master_write;
  logic [AW-1:0] master_address;
  logic [3:0]    master_select;
  logic [DW-1:0] master_write_data;
  logic          master_ready;
  logic          master_error;
  logic [DW-1:0] master_read_data;
  logic [SC-1:0] slave_request;
  logic          slave_write;
  logic [AW-1:0] slave_address;
  logic [3:0]    slave_select;
  logic [DW-1:0] slave_write_data;
  logic [SC-1:0] slave_ready;
  logic [SC*DW-1:0] slave_read_data;

  int total = 0;
  int bad   = 0;

  system_bus #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .SLAVE_COUNT(SC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .master_request(master_request), .master_write(master_write),
    .master_address(master_address), .master_select(master_select),
    .master_write_data(master_write_data),
    .master_ready(master_ready), .master_error(master_error),
    .master_read_data(master_read_data),
    .slave_request(slave_request), .slave_write(slave_write),
    .slave_address(slave_address), .slave_select(slave_select),
    .slave_write_data(slave_write_data),
    .slave_ready(slave_ready), .slave_read_data(slave_read_data)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic wr, input logic [AW-1:0] addr,
                       input logic [3:0] sel, input logic [DW-1:0] wd);
    master_request    = 1'b1;
    master_write      = wr;
    master_address    = addr;
    master_select     = sel;
    master_write_data = wd;
  endtask

  initial begin
    reset = 1'b1;
    master_request = 1'b0; master_write = 1'b0; master_address = '0;
    master_select = '0; master_write_data = '0;
    slave_ready = '0; slave_read_data = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_ready", master_ready, 1'b0);
    chk("rst_error", master_error, 1'b0);
    chk("rst_rdata", master_read_data, 32'h0);
    chk("rst_sreq",  slave_request, 3'b000);
    chk("rst_saddr", slave_address, 32'h0);
    chk("rst_swdat", slave_write_data, 32'h0);

    // Zero-wait read from slave 1 (ready tied high)
    slave_ready = 3'b010;
    slave_read_data[1*DW +: DW] = 32'hDEADBEEF;
    start(1'b0, 32'h4000_0010, 4'hF, 32'h0);
    tick();
    chk("zw_sreq_c1",  slave_request, 3'b010);
    chk("zw_ready_c1", master_ready, 1'b0);
    chk("zw_saddr",    slave_address, 32'h4000_0010);
    chk("zw_swrite",   slave_write, 1'b0);
    tick();
    chk("zw_ready_c2", master_ready, 1'b1);
    chk("zw_error_c2", master_error, 1'b0);
    chk("zw_rdata_c2", master_read_data, 32'hDEADBEEF);
    chk("zw_sreq_c2",  slave_request, 3'b000);
    master_request = 1'b0;
    slave_ready = 3'b000;
    tick();
    chk("zw_ready_c3", master_ready, 1'b0);
    chk("zw_rdata_c3", master_read_data, 32'h0);

    // Wait-state write to slave 2, ready at cycle 5, noise from slave 0 at cycle 3
    slave_read_data[2*DW +: DW] = 32'hFFFF_FFFF;
    start(1'b1, 32'h8000_0000, 4'b0011, 32'h0000_1234);
    tick();
    chk("ws_sreq_c1",  slave_request, 3'b100);
    chk("ws_swrite",   slave_write, 1'b1);
    chk("ws_ssel",     slave_select, 4'b0011);
    chk("ws_swdat_c1", slave_write_data, 32'h1234);
    for (int c = 2; c <= 4; c++) begin
      slave_ready = (c == 3) ? 3'b001 : 3'b000;
      tick();
      chk("ws_sreq_wait",  slave_request, 3'b100);
      chk("ws_ready_wait", master_ready, 1'b0);
      chk("ws_swdat_wait", slave_write_data, 32'h1234);
    end
    slave_ready = 3'b000;
    tick();
    // Cycle 5: slave 2 completes
    chk("ws_sreq_c5", slave_request, 3'b100);
    slave_ready = 3'b100;
    tick();
    chk("ws_ready_c6", master_ready, 1'b1);
    chk("ws_error_c6", master_error, 1'b0);
    chk("ws_rdata_c6", master_read_data, 32'h0);
    chk("ws_swdat_c6", slave_write_data, 32'h1234);
    master_request = 1'b0;
    slave_ready = 3'b000;
    tick();

    // Timeout on slave 0; slave 1 holds ready high and must be ignored
    slave_read_data[0 +: DW] = 32'hAAAA_5555;
    slave_ready = 3'b010;
    start(1'b0, 32'h0000_0004, 4'hF, 32'h0);
    for (int c = 1; c <= TO; c++) begin
      tick();
      chk("to_sreq_wait",  slave_request, 3'b001);
      chk("to_ready_wait", master_ready, 1'b0);
    end
    tick();
    chk("to_ready_c9", master_ready, 1'b1);
    chk("to_error_c9", master_error, 1'b1);
    chk("to_rdata_c9", master_read_data, 32'h0);
    chk("to_sreq_c9",  slave_request, 3'b000);
    master_request = 1'b0;
    slave_ready = 3'b000;
    tick();

    // Unmapped region (index 3 with only 3 slaves)
    slave_ready = 3'b111;
    start(1'b0, 32'hC000_0000, 4'hF, 32'h0);
    tick();
    chk("um_sreq_c1",  slave_request, 3'b000);
    chk("um_ready_c1", master_ready, 1'b0);
    tick();
    chk("um_sreq_c2",  slave_request, 3'b000);
    chk("um_ready_c2", master_ready, 1'b1);
    chk("um_error_c2", master_error, 1'b1);
    chk("um_rdata_c2", master_read_data, 32'h0);
    master_request = 1'b0;
    slave_ready = 3'b000;
    tick();

    // Ready arrives on the timeout cycle: ready wins
    slave_read_data[1*DW +: DW] = 32'h0BAD_F00D;
    start(1'b0, 32'h4000_0000, 4'hF, 32'h0);
    for (int c = 1; c <= TO; c++) begin
      tick();
      chk("race_sreq", slave_request, 3'b010);
    end
    slave_ready = 3'b010;
    tick();
    chk("race_ready", master_ready, 1'b1);
    chk("race_error", master_error, 1'b0);
    chk("race_rdata", master_read_data, 32'h0BAD_F00D);
    master_request = 1'b0;
    slave_ready = 3'b000;
    tick();

    // Reset during a waiting access, then normal back-to-back service
    start(1'b0, 32'h8000_0008, 4'hF, 32'h0);
    tick();
    chk("rm_sreq_c1", slave_request, 3'b100);
    tick();
    reset = 1'b1;
    master_request = 1'b0;
    tick();
    chk("rm_sreq",  slave_request, 3'b000);
    chk("rm_ready", master_ready, 1'b0);
    chk("rm_saddr", slave_address, 32'h0);
    reset = 1'b0;
    slave_ready = 3'b100;
    tick();
    chk("rm_dropped", master_ready, 1'b0);
    slave_ready = 3'b001;
    slave_read_data[0 +: DW] = 32'h1122_3344;
    start(1'b0, 32'h0000_0000, 4'hF, 32'h0);
    tick();
    chk("rm_new_sreq", slave_request, 3'b001);
    tick();
    chk("rm_new_ready", master_ready, 1'b1);
    chk("rm_new_rdata", master_read_data, 32'h1122_3344);
    // Request left high: the following IDLE cycle starts a new transaction
    tick();
    chk("b2b_idle_ready", master_ready, 1'b0);
    chk("b2b_idle_sreq",  slave_request, 3'b000);
    tick();
    chk("b2b_sreq", slave_request, 3'b001);
    master_request = 1'b0;
    tick();
    chk("b2b_ready", master_ready, 1'b1);
    chk("b2b_rdata", master_read_data, 32'h1122_3344);
    slave_ready = 3'b000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/system_bus.md
Name: system_bus

Overview:
- Parametrised single-master data-bus interconnect between the cpu data port and SLAVE_COUNT memory-mapped slaves (ram, rom mirror, peripherals).
- Replaces point-to-point cpu-to-ram wiring in the SoC top level.
- Adds address-region decoding, variable wait-state handshaking, registered read-data return, and a timeout that returns a bus error for unresponsive or unmapped slaves.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8.
- ADDRESS_WIDTH, 32, byte address width.
- SLAVE_COUNT, 4, number of slave channels; range 2..16.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles waiting for slave_ready before an error response; range 1..65535.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- master_request  in  1  transaction request. Request and payload are held stable through the cycle master_ready=1.
- master_write  in  1  1 = write, 0 = read.
- master_address  in  ADDRESS_WIDTH  byte address.
- master_select  in  DATA_WIDTH/8  byte-lane enables for writes.
- master_write_data  in  DATA_WIDTH  write data.
- master_ready  out  1  one-cycle completion pulse.
- master_error  out  1  valid with master_ready; 1 = unmapped or timed out.
- master_read_data  out  DATA_WIDTH  read data; valid with master_ready, otherwise 0.
- slave_request  out  SLAVE_COUNT  one-hot request to the selected slave.
- slave_write  out  1  latched write flag.
- slave_address  out  ADDRESS_WIDTH  latched address.
- slave_select  out  DATA_WIDTH/8  latched byte enables.
- slave_write_data  out  DATA_WIDTH  latched write data.
- slave_ready  in  SLAVE_COUNT  per-slave completion.
- slave_read_data  in  SLAVE_COUNT*DATA_WIDTH  packed read data; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset: when reset=1 at an edge, state goes to IDLE. All outputs and all latched registers go to 0, including an in-flight slave_request (drops at that edge). A pending transaction is dropped without a response.
- Decode: SLAVE_BITS = clog2(SLAVE_COUNT). index = master_address[ADDRESS_WIDTH-1 -: SLAVE_BITS]. index >= SLAVE_COUNT is unmapped.
- FSM states: IDLE, ACCESS, ERROR, RESPOND.
- IDLE:
  - master_request=1 latches write, address, select, write_data and index.
  - Mapped index: go to ACCESS and clear the timeout counter.
  - Unmapped index: go to ERROR.
  - Requests are sampled only in IDLE.
- ACCESS:
  - slave_request[index]=1; all other bits 0.
  - slave_ready[index]=1: capture read data (reads only; writes capture 0) and go to RESPOND with error=0.
  - Otherwise the counter increments. If counter==TIMEOUT_CYCLES-1, go to RESPOND with error=1 and read data 0.
  - If ready and timeout occur in the same cycle, ready wins (error=0).
- ERROR: one cycle with no slave request, then RESPOND with error=1.
- RESPOND: master_ready=1 for exactly one cycle, with master_error and master_read_data registered. Next state is IDLE.
- A request seen high in the IDLE cycle after RESPOND is a new transaction.
- Latency:
  - Request in IDLE at cycle 0 gives slave_request from cycle 1.
  - Ready at cycle k gives master_ready at cycle k+1; a zero-wait slave completes at cycle 2.
  - Timeout: slave_request is high for TIMEOUT_CYCLES cycles, and master_ready+master_error occur at cycle TIMEOUT_CYCLES+1.
  - Unmapped: master_ready+master_error at cycle 2.
- Ignored inputs: slave_ready bits of non-selected slaves, and all slave_ready bits outside ACCESS.
- Throughput: minimum transaction period is 3 cycles (IDLE, ACCESS, RESPOND).
- slave_* payload outputs hold their latched values until the next accepted request.

Decomposition:
- Shared defines file holds:
  - FSM state encodings: BUS_STATE_IDLE, BUS_STATE_ACCESS, BUS_STATE_ERROR, BUS_STATE_RESPOND.
  - BUS_ERROR / BUS_OK constants.
  - Existing RESET_ENABLE / CHIP_ENABLE macros, reused.
- One sub-module: bus_timeout_counter, parametrised by TIMEOUT_CYCLES.
  - Inputs: clear, enable.
  - Output: expired.
  - Counter width is clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Zero-wait read: SLAVE_COUNT=4, slave 1 ties ready=1 and data 0xDEADBEEF, read 0x4000_0010 -> slave_request=4'b0010 in cycle 1; master_ready=1, error=0, data 0xDEADBEEF in cycle 2.
- Wait-state write: slave 2 asserts ready 5 cycles after request, write 0x8000_0000, select 4'b0011, data 0x1234 -> slave_write_data=0x1234 held stable; master_ready at the cycle after ready; read_data=0.
- Timeout: TIMEOUT_CYCLES=8, slave 3 never ready -> slave_request[3] high for exactly 8 cycles; master_ready=1, error=1, data 0 at cycle 9.
- Unmapped: SLAVE_COUNT=3, address 0xC000_0000 -> no slave_request bit ever set; master_ready+error at cycle 2.
- Race and noise: ready arrives on the timeout cycle -> error=0. Non-selected slave_ready pulses during ACCESS -> ignored.
- Reset mid-ACCESS: assert reset during a waiting access -> next edge: slave_request=0, master_ready=0, state IDLE; next request serviced normally.
